// File: rtl/sddr_arb_pkg.sv
// rtl/sddr_arb_pkg.sv - shared types, default widths and round-robin helper for the port arbiter
package sddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    localparam int DEF_ADDRESS_BITS  = 27;
    localparam int DEF_CMD_DATA_BITS = 128;

    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/sddr_rr_grant.sv
// rtl/sddr_rr_grant.sv - combinational one-hot round-robin grant starting at the pointer
module sddr_rr_grant
    import sddr_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_rr_ptr,
    output logic [NUM_PORTS-1:0] o_grant
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = PTR_W'((int'(i_rr_ptr) + k) % NUM_PORTS);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sddr_port_arbiter.sv
// rtl/sddr_port_arbiter.sv - round-robin sharing of the DDR data command port; SDDR_ARB_TIMEOUT_EN adds a read watchdog
module sddr_port_arbiter
    import sddr_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ADDRESS_BITS  = DEF_ADDRESS_BITS,
    parameter int CMD_DATA_BITS = DEF_CMD_DATA_BITS,
    parameter int RSP_TIMEOUT   = 4096
) (
    input  logic                               cpu_clock_i,
    input  logic                               reset_n_i,
    input  logic [NUM_PORTS-1:0]               port_cmd_valid_i,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0]  port_cmd_address_i,
    input  logic [NUM_PORTS-1:0]               port_cmd_write_i,
    input  logic [NUM_PORTS*CMD_DATA_BITS-1:0] port_cmd_data_i,
    output logic [NUM_PORTS-1:0]               port_cmd_ack_o,
    output logic [NUM_PORTS-1:0]               port_rsp_ready_o,
    output logic [CMD_DATA_BITS-1:0]           port_rsp_data_o,
    output logic                               port_rsp_error_o,
    output logic                               mem_cmd_valid_o,
    output logic [ADDRESS_BITS-1:0]            mem_cmd_address_o,
    output logic                               mem_cmd_write_o,
    output logic [CMD_DATA_BITS-1:0]           mem_cmd_data_o,
    input  logic                               mem_cmd_ack_i,
    input  logic                               mem_rsp_ready_i,
    input  logic [CMD_DATA_BITS-1:0]           mem_rsp_data_i,
    output logic                               busy_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_e               r_state, w_state_nxt;
    logic [PTR_W-1:0]         r_rr_ptr;
    logic [PTR_W-1:0]         r_owner;
    logic                     r_cmd_valid;
    logic [ADDRESS_BITS-1:0]  r_cmd_addr;
    logic                     r_cmd_write;
    logic [CMD_DATA_BITS-1:0] r_cmd_data;
    logic [NUM_PORTS-1:0]     r_rsp_ready;
    logic [CMD_DATA_BITS-1:0] r_rsp_data;
    logic                     r_rsp_error;

    logic [NUM_PORTS-1:0]     w_grant;
    logic [PTR_W-1:0]         w_winner;
    logic                     w_xfer;
    logic                     w_timeout;
    logic [NUM_PORTS-1:0]     w_owner_onehot;

    sddr_rr_grant #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_grant (
        .i_req     (port_cmd_valid_i),
        .i_rr_ptr  (r_rr_ptr),
        .o_grant   (w_grant)
    );

    always_comb begin
        w_winner = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) w_winner = PTR_W'(i);
        end
    end

    assign w_xfer         = (r_state == IDLE) && (|w_grant);
    assign w_owner_onehot = NUM_PORTS'(1) << r_owner;

`ifdef SDDR_ARB_TIMEOUT_EN
    localparam int TO_W = ($clog2(RSP_TIMEOUT) > 13) ? $clog2(RSP_TIMEOUT) : 13;
    logic [TO_W-1:0] r_to_cnt;

    // The ISSUE cycle clears the counter so it reads 0 on the first WAIT_RSP cycle.
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_to_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_to_cnt <= '0;
        end else if (r_state == WAIT_RSP) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == WAIT_RSP) && !mem_rsp_ready_i &&
                       (r_to_cnt == TO_W'(RSP_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_xfer) w_state_nxt = ISSUE;
            ISSUE:    if (mem_cmd_ack_i) w_state_nxt = r_cmd_write ? IDLE : WAIT_RSP;
            WAIT_RSP: if (mem_rsp_ready_i || w_timeout) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_write <= 1'b0;
            r_cmd_data  <= '0;
            r_rsp_ready <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_ready <= '0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_cmd_addr  <= port_cmd_address_i[w_winner*ADDRESS_BITS +: ADDRESS_BITS];
                        r_cmd_write <= port_cmd_write_i[w_winner];
                        r_cmd_data  <= port_cmd_data_i[w_winner*CMD_DATA_BITS +: CMD_DATA_BITS];
                        r_cmd_valid <= 1'b1;
                        r_owner     <= w_winner;
                        r_rr_ptr    <= PTR_W'(rr_next(32'(w_winner), NUM_PORTS));
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ack_i) r_cmd_valid <= 1'b0;
                end
                WAIT_RSP: begin
                    // A real response beats a watchdog expiry in the same cycle.
                    if (mem_rsp_ready_i) begin
                        r_rsp_ready <= w_owner_onehot;
                        r_rsp_data  <= mem_rsp_data_i;
                        r_rsp_error <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_ready <= w_owner_onehot;
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign port_cmd_ack_o    = (r_state == IDLE) ? w_grant : '0;
    assign port_rsp_ready_o  = r_rsp_ready;
    assign port_rsp_data_o   = r_rsp_data;
    assign port_rsp_error_o  = r_rsp_error;
    assign mem_cmd_valid_o   = r_cmd_valid;
    assign mem_cmd_address_o = r_cmd_addr;
    assign mem_cmd_write_o   = r_cmd_write;
    assign mem_cmd_data_o    = r_cmd_data;
    assign busy_o            = (r_state != IDLE);

endmodule

// File: tb/tb_sddr_port_arbiter.sv
// tb/tb_sddr_port_arbiter.sv - directed self-checking bench for sddr_port_arbiter
module tb_sddr_port_arbiter;

    localparam int NP = 2;
    localparam int AB = 27;
    localparam int DB = 128;
`ifdef SDDR_ARB_TIMEOUT_EN
    localparam int RSP_DELAY = 10;
`else
    localparam int RSP_DELAY = 30;
`endif

    localparam logic [AB-1:0] ADDR0 = 27'h0000040;
    localparam logic [AB-1:0] ADDR1 = 27'h0123456;
    localparam logic [DB-1:0] WDATA = {16{8'hA5}};
    localparam logic [DB-1:0] RDATA = 128'h00112233445566778899AABBCCDDEEFF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    port_cmd_valid;
    logic [NP*AB-1:0] port_cmd_address;
    logic [NP-1:0]    port_cmd_write;
    logic [NP*DB-1:0] port_cmd_data;
    logic [NP-1:0]    port_cmd_ack;
    logic [NP-1:0]    port_rsp_ready;
    logic [DB-1:0]    port_rsp_data;
    logic             port_rsp_error;
    logic             mem_cmd_valid;
    logic [AB-1:0]    mem_cmd_address;
    logic             mem_cmd_write;
    logic [DB-1:0]    mem_cmd_data;
    logic             mem_cmd_ack;
    logic             mem_rsp_ready;
    logic [DB-1:0]    mem_rsp_data;
    logic             busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sddr_port_arbiter #(
        .NUM_PORTS     (NP),
        .ADDRESS_BITS  (AB),
        .CMD_DATA_BITS (DB),
        .RSP_TIMEOUT   (16)
    ) dut (
        .cpu_clock_i        (clk),
        .reset_n_i          (rst_n),
        .port_cmd_valid_i   (port_cmd_valid),
        .port_cmd_address_i (port_cmd_address),
        .port_cmd_write_i   (port_cmd_write),
        .port_cmd_data_i    (port_cmd_data),
        .port_cmd_ack_o     (port_cmd_ack),
        .port_rsp_ready_o   (port_rsp_ready),
        .port_rsp_data_o    (port_rsp_data),
        .port_rsp_error_o   (port_rsp_error),
        .mem_cmd_valid_o    (mem_cmd_valid),
        .mem_cmd_address_o  (mem_cmd_address),
        .mem_cmd_write_o    (mem_cmd_write),
        .mem_cmd_data_o     (mem_cmd_data),
        .mem_cmd_ack_i      (mem_cmd_ack),
        .mem_rsp_ready_i    (mem_rsp_ready),
        .mem_rsp_data_i     (mem_rsp_data),
        .busy_o             (busy)
    );

    task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge in IDLE with requests already driven.
    task automatic serve_read(input logic [NP-1:0] exp_grant, input logic [DB-1:0] rdata,
                              input int delay, input logic [NP-1:0] hold);
        #1;
        check("rd_ack", DB'(port_cmd_ack), DB'(exp_grant));
        @(posedge clk); #1;
        port_cmd_valid = hold;
        @(negedge clk);
        check("rd_mval", DB'(mem_cmd_valid), DB'(1'b1));
        check("rd_addr", DB'(mem_cmd_address), DB'(exp_grant[1] ? ADDR1 : ADDR0));
        check("rd_wr", DB'(mem_cmd_write), DB'(1'b0));
        check("rd_ack_issue", DB'(port_cmd_ack), '0);
        mem_cmd_ack = 1'b1;
        @(posedge clk); #1;
        mem_cmd_ack = 1'b0;
        repeat (delay) @(negedge clk);
        check("rd_wait_rdy", DB'(port_rsp_ready), '0);
        check("rd_wait_busy", DB'(busy), DB'(1'b1));
        mem_rsp_ready = 1'b1;
        mem_rsp_data  = rdata;
        @(posedge clk); #1;
        mem_rsp_ready = 1'b0;
        @(negedge clk);
        check("rd_rsp_rdy", DB'(port_rsp_ready), DB'(exp_grant));
        check("rd_rsp_data", port_rsp_data, rdata);
        check("rd_rsp_err", DB'(port_rsp_error), '0);
    endtask

    initial begin
        rst_n            = 1'b0;
        port_cmd_valid   = '0;
        port_cmd_write   = '0;
        port_cmd_address = {ADDR1, ADDR0};
        port_cmd_data    = {WDATA, {DB{1'b0}}};
        mem_cmd_ack      = 1'b0;
        mem_rsp_ready    = 1'b0;
        mem_rsp_data     = '0;

        repeat (2) @(negedge clk);
        check("rst_ack", DB'(port_cmd_ack), '0);
        check("rst_mval", DB'(mem_cmd_valid), '0);
        check("rst_busy", DB'(busy), '0);
        check("rst_rdy", DB'(port_rsp_ready), '0);
        check("rst_data", port_rsp_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // port 1 write, controller acks after 10 cycles
        @(negedge clk);
        port_cmd_valid = 2'b10;
        port_cmd_write = 2'b10;
        #1;
        check("wr_ack", DB'(port_cmd_ack), DB'(2'b10));
        @(posedge clk); #1;
        port_cmd_valid = '0;
        port_cmd_write = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("wr_mval", DB'(mem_cmd_valid), DB'(1'b1));
            check("wr_addr", DB'(mem_cmd_address), DB'(ADDR1));
            check("wr_data", mem_cmd_data, WDATA);
            check("wr_wr", DB'(mem_cmd_write), DB'(1'b1));
        end
        mem_cmd_ack = 1'b1;
        @(posedge clk); #1;
        mem_cmd_ack = 1'b0;
        @(negedge clk);
        check("wr_mval_off", DB'(mem_cmd_valid), '0);
        check("wr_busy_off", DB'(busy), '0);
        check("wr_no_rsp", DB'(port_rsp_ready), '0);

        // stray response while IDLE is ignored
        mem_rsp_ready = 1'b1;
        mem_rsp_data  = {8{16'hDEAD}};
        @(posedge clk); #1;
        mem_rsp_ready = 1'b0;
        @(negedge clk);
        check("stray_rdy", DB'(port_rsp_ready), '0);
        check("stray_data", port_rsp_data, '0);

        // port 0 read with a long response latency
        port_cmd_valid = 2'b01;
        serve_read(2'b01, RDATA, RSP_DELAY, 2'b00);
        @(negedge clk);
        check("rd_pulse_end", DB'(port_rsp_ready), '0);
        check("rd_data_hold", port_rsp_data, RDATA);
        check("rd_busy_off", DB'(busy), '0);

        // reset while waiting for a read response
        port_cmd_valid = 2'b01;
        #1;
        check("rm_ack", DB'(port_cmd_ack), DB'(2'b01));
        @(posedge clk); #1;
        port_cmd_valid = '0;
        @(negedge clk);
        mem_cmd_ack = 1'b1;
        @(posedge clk); #1;
        mem_cmd_ack = 1'b0;
        @(negedge clk);
        check("rm_busy_wait", DB'(busy), DB'(1'b1));
        rst_n = 1'b0;
        #1;
        check("rm_busy_rst", DB'(busy), '0);
        check("rm_mval_rst", DB'(mem_cmd_valid), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        mem_rsp_ready = 1'b1;
        mem_rsp_data  = {8{16'hBEEF}};
        @(posedge clk); #1;
        mem_rsp_ready = 1'b0;
        @(negedge clk);
        check("rm_late_rdy", DB'(port_rsp_ready), '0);
        check("rm_busy", DB'(busy), '0);
        check("rm_data", port_rsp_data, '0);

        // both ports continuously valid: grants rotate 0,1,0,1 starting from reset pointer
        port_cmd_valid = 2'b11;
        serve_read(2'b01, 128'h1, 3, 2'b11);
        serve_read(2'b10, 128'h2, 3, 2'b11);
        serve_read(2'b01, 128'h3, 3, 2'b11);
        serve_read(2'b10, 128'h4, 3, 2'b11);
        port_cmd_valid = '0;
        @(negedge clk);
        check("rr_idle", DB'(busy), '0);

`ifdef SDDR_ARB_TIMEOUT_EN
        // unanswered read: watchdog pulse 16 cycles after entering WAIT_RSP
        port_cmd_valid = 2'b01;
        #1;
        check("to_ack", DB'(port_cmd_ack), DB'(2'b01));
        @(posedge clk); #1;
        port_cmd_valid = '0;
        @(negedge clk);
        mem_cmd_ack = 1'b1;
        @(posedge clk); #1;
        mem_cmd_ack = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("to_early", DB'(port_rsp_ready), '0);
        end
        @(negedge clk);
        check("to_rdy", DB'(port_rsp_ready), DB'(2'b01));
        check("to_data", port_rsp_data, '0);
        check("to_err", DB'(port_rsp_error), DB'(1'b1));
        @(negedge clk);
        check("to_end", DB'(port_rsp_ready), '0);
        check("to_busy", DB'(busy), '0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
